// File: rtl/spm_pkg.sv
// spm_pkg: shared types and sizing for the SPM sequencer
// Holds the FSM state encoding and the default operand/product/counter widths.
package spm_pkg;
    localparam int SPM_WIDTH = 8;
    localparam int PROD_W    = 2 * SPM_WIDTH;
    localparam int CNT_W     = $clog2(PROD_W);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/spm_bit_counter.sv
// spm_bit_counter: loadable up-counter that saturates at a terminal count
// Ports: clk_i clock; reset_i sync active-low reset; load_i clears the count;
//        en_i advances the count; cnt_o current count; tc_o count == TERM.
module spm_bit_counter #(
    parameter int CNT_W = 4,
    parameter int TERM  = 2**CNT_W - 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        tc_o  = cnt_q == CNT_W'(TERM);
        cnt_d = load_i ? '0 : (en_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/spm_sequencer.sv
// spm_sequencer: drives one signed serial-parallel multiply per start request
// Ports: clk_i clock; reset_i sync active-low reset; start_pulse_i/clear_pulse_i
//        one-cycle button requests; mcand_in_i/mplier_in_i operand switches;
//        spm_x_o latched multiplicand; spm_y_o serial multiplier bit;
//        spm_clr_o SPM clear; spm_p_i serial product bit; product_o assembled
//        product; busy_o operation in progress; done_o product held.
module spm_sequencer
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_pulse_i,
    input  logic               clear_pulse_i,
    input  logic [WIDTH-1:0]   mcand_in_i,
    input  logic [WIDTH-1:0]   mplier_in_i,
    output logic [WIDTH-1:0]   spm_x_o,
    output logic               spm_y_o,
    output logic               spm_clr_o,
    input  logic               spm_p_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);
    state_e          state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [PW-1:0]   sr_q, sr_d, prod_q, prod_d;
    logic [CW-1:0]   cnt;
    logic            cnt_load, cnt_en, tc, first;
    spm_bit_counter #(.CNT_W(CW), .TERM(PW - 1)) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (cnt_load),
        .en_i    (cnt_en),
        .cnt_o   (cnt),
        .tc_o    (tc)
    );
    assign first = cnt == '0;
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        sr_d     = sr_q;
        prod_d   = prod_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        if (clear_pulse_i) begin
            state_d = IDLE;
            prod_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_pulse_i) begin
                    x_d      = mcand_in_i;
                    y_d      = mplier_in_i;
                    cnt_load = 1'b1;
                    state_d  = CLEAR;
                end
                CLEAR: state_d = SHIFT;
                SHIFT: begin
                    // arithmetic shift feeds sign extension for the upper product bits
                    y_d    = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                    // first shift drops whatever the previous run left behind
                    sr_d   = {spm_p_i, first ? {(PW-1){1'b0}} : sr_q[PW-1:1]};
                    cnt_en = 1'b1;
                    prod_d = first ? '0 : prod_q;
                    if (tc) begin
                        state_d = DONE;
                        prod_d  = sr_d;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sr_q    <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sr_q    <= sr_d;
            prod_q  <= prod_d;
        end
    end
    assign spm_x_o   = x_q;
    assign spm_y_o   = (state_q == SHIFT) && y_q[0];
    assign spm_clr_o = state_q == CLEAR;
    assign busy_o    = (state_q == CLEAR) || (state_q == SHIFT);
    assign done_o    = state_q == DONE;
    assign product_o = prod_q;
endmodule

// File: tb/tb_spm_sequencer.sv
// tb_spm_sequencer: self-checking bench with a behavioural serial multiplier
module tb_spm_sequencer;
    localparam int W  = 8;
    localparam int PW = 16;
    logic clk = 0, reset = 0, start = 0, clr = 0;
    logic [W-1:0] mcand = '0, mplier = '0, spm_x;
    logic spm_y, spm_clr, spm_p, busy, done;
    logic [PW-1:0] product;
    int checks = 0, errors = 0;
    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] p;
    } vec_t;
    vec_t tbl [6];
    always #5 clk = ~clk;
    spm_sequencer #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_pulse_i (start),
        .clear_pulse_i (clr),
        .mcand_in_i    (mcand),
        .mplier_in_i   (mplier),
        .spm_x_o       (spm_x),
        .spm_y_o       (spm_y),
        .spm_clr_o     (spm_clr),
        .spm_p_i       (spm_p),
        .product_o     (product),
        .busy_o        (busy),
        .done_o        (done)
    );
    // SPM model: product bit k depends only on multiplier bits 0..k
    logic [PW-1:0] m_y = '0, m_xs, m_yv, m_pp;
    logic [4:0]    m_k = '0;
    always_comb begin
        m_xs  = {{W{spm_x[W-1]}}, spm_x};
        m_yv  = m_y | (PW'(spm_y) << m_k);
        m_pp  = m_xs * m_yv;
        spm_p = m_pp[m_k[3:0]];
    end
    always @(posedge clk) begin
        if (spm_clr) begin
            m_y <= '0;
            m_k <= '0;
        end else if (busy) begin
            m_y <= m_yv;
            m_k <= m_k + 5'd1;
        end
    end
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input int cyc);
        tick();
        mcand = a;
        mplier = b;
        start = 1;
        repeat (cyc) begin
            tick();
            start = 0;
        end
    endtask
    // inj_n > 0: fire a second start with other switches during cycle inj_n
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] exp,
                          input int inj_n, input logic [W-1:0] ia, input logic [W-1:0] ib);
        int n, nclr;
        go(a, b, 1);
        n = 1;
        nclr = int'(spm_clr);
        chk("busy_in_clear", 32'(busy), 32'd1);
        chk("done_in_clear", 32'(done), 32'd0);
        while (!done && n < 40) begin
            if (n == inj_n) begin
                mcand = ia;
                mplier = ib;
                start = 1;
            end
            tick();
            start = 0;
            n++;
            nclr += int'(spm_clr);
            if (inj_n > 0 && n == inj_n + 1) chk("spm_x_held", 32'(spm_x), 32'(a));
        end
        chk("latency", n, 32'd18);
        chk("clr_pulses", nclr, 32'd1);
        chk("product", 32'(product), 32'(exp));
        chk("spm_x", 32'(spm_x), 32'(a));
        chk("busy_done", 32'(busy), 32'd0);
    endtask
    initial begin
        logic [W-1:0] ra, rb;
        tbl = '{'{8'h05, 8'h03, 16'h000F}, '{8'hFF, 8'hFF, 16'h0001},
                '{8'h80, 8'h7F, 16'hC080}, '{8'h80, 8'h80, 16'h4000},
                '{8'h7F, 8'h80, 16'hC080}, '{8'h00, 8'h9C, 16'h0000}};
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_spm_clr", 32'(spm_clr), 32'd0);
        chk("rst_spm_x", 32'(spm_x), 32'd0);
        reset = 1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_product", 32'(product), 32'd0);
        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].p, 0, 8'h00, 8'h00);
        // second start during SHIFT k=5 must be ignored
        run_op(8'h12, 8'h34, 16'h03A8, 7, 8'hEE, 8'h77);
        // clear during SHIFT k=7
        go(8'h37, 8'hC5, 9);
        clr = 1;
        tick();
        clr = 0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_product", 32'(product), 32'd0);
        chk("clr_spm_y", 32'(spm_y), 32'd0);
        run_op(8'h37, 8'hC5, ref_mul(8'h37, 8'hC5), 0, 8'h00, 8'h00);
        // start and clear together from DONE: clear wins
        run_op(8'h7F, 8'h7F, 16'h3F01, 0, 8'h00, 8'h00);
        start = 1;
        clr = 1;
        tick();
        start = 0;
        clr = 0;
        chk("sc_busy", 32'(busy), 32'd0);
        chk("sc_done", 32'(done), 32'd0);
        chk("sc_product", 32'(product), 32'd0);
        chk("sc_spm_clr", 32'(spm_clr), 32'd0);
        tick();
        chk("sc_spm_clr2", 32'(spm_clr), 32'd0);
        chk("sc_busy2", 32'(busy), 32'd0);
        // reset during SHIFT k=10, start while reset low is ignored
        go(8'hA5, 8'h3C, 12);
        reset = 0;
        tick();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_product", 32'(product), 32'd0);
        chk("mrst_spm_x", 32'(spm_x), 32'd0);
        chk("mrst_spm_y", 32'(spm_y), 32'd0);
        mcand = 8'h11;
        start = 1;
        tick();
        start = 0;
        reset = 1;
        tick();
        chk("mrst_start_ignored", 32'(busy), 32'd0);
        chk("mrst_spm_clr", 32'(spm_clr), 32'd0);
        chk("mrst_spm_x2", 32'(spm_x), 32'd0);
        repeat (30) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, ref_mul(ra, rb), 0, 8'h00, 8'h00);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spm_sequencer.md
Name: spm_sequencer

Overview:
- Controller that runs one signed 8-bit serial-parallel multiply (SPM) per start request.
- Sits between the push-button front end (one-cycle pulses from the push-button detectors) and the SPM datapath.
- Latches the operands, clears the SPM, and streams the multiplier LSB-first with sign extension for 2*WIDTH cycles.
- Deserialises the product bits into a parallel register and holds it for the display.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- start_pulse  input  1  one-cycle start request from the push-button detector
- clear_pulse  input  1  one-cycle abort/clear request from the push-button detector
- mcand_in  input  WIDTH  multiplicand switches, two's complement
- mplier_in  input  WIDTH  multiplier switches, two's complement
- spm_x  output  WIDTH  latched multiplicand, parallel operand to the SPM
- spm_y  output  1  serial multiplier bit to the SPM
- spm_clr  output  1  one-cycle synchronous clear of the SPM internal state
- spm_p  input  1  serial product bit from the SPM
- product  output  2*WIDTH  assembled signed product
- busy  output  1  high while an operation is in progress (CLEAR or SHIFT)
- done  output  1  high while a completed product is held (DONE state)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; all outputs 0; operand, product and counter registers 0.
  - Reset overrides every other input, including mid-operation.
- States: IDLE, CLEAR, SHIFT, DONE; binary encoding from the package.
- Priority every cycle: reset > clear_pulse > start_pulse.
- clear_pulse in any state:
  - next state IDLE; product<=0; done=0; busy=0.
  - spm_clr is not asserted by clear.
- IDLE or DONE with start_pulse (and no clear_pulse):
  - latch mcand_in -> x_reg and mplier_in -> y_reg; counter<=0; next state CLEAR.
  - product is not cleared until the first SHIFT cycle; done drops in CLEAR.
- CLEAR (exactly 1 cycle): spm_clr=1, busy=1; next state SHIFT.
- SHIFT (exactly 2*WIDTH cycles, counter k = 0 .. 2*WIDTH-1):
  - spm_y = y_reg[0].
  - At each edge, y_reg shifts right arithmetically (MSB replicated), so bits WIDTH and above are sign extension.
  - The SPM presents product bit k on spm_p during SHIFT cycle k.
  - At each edge: prod_sr <= {spm_p, prod_sr[2W-1:1]}. At k=0 the shift input is cleared, so stale bits are discarded.
  - On the edge where k==2*WIDTH-1: next state DONE; product <= final assembled value.
- DONE:
  - done=1, busy=0.
  - product stable until the next start or clear.
  - spm_y=0 and spm_clr=0.
- start_pulse while busy: ignored, with no restart and no queuing.
- spm_x = x_reg at all times. It is stable from CLEAR through DONE and never changes mid-operation, even if the switches move.
- Total latency from start_pulse edge to done=1: 1 (latch) + 1 (CLEAR) + 2*WIDTH (SHIFT) = 18 cycles for WIDTH=8.
- Product arithmetic:
  - product = signed(mcand) * signed(mplier), truncated to 2*WIDTH bits.
  - The -2^(W-1) * -2^(W-1) case yields +2^(2W-2), which fits in 2*WIDTH bits.
- Counter width: clog2(2*WIDTH) bits. It saturates at the terminal count, with no wrap-around into a second pass.

Decomposition:
- Package spm_pkg:
  - state typedef/localparams (IDLE, CLEAR, SHIFT, DONE)
  - default WIDTH
  - PROD_W = 2*WIDTH
  - CNT_W = clog2(PROD_W)
- One sub-module: spm_bit_counter (load/enable/terminal-count flag, parameterised by CNT_W).
- The FSM and shift registers stay in spm_sequencer.

Test Plan:
- All scenarios use a behavioural SPM model.
- reset low 3 cycles, then high -> busy=0, done=0, product=0x0000, spm_clr=0; start_pulse with mcand=0x05, mplier=0x03 -> spm_clr high exactly 1 cycle, done rises 18 cycles after start, product=0x000F.
- mcand=0xFF (-1), mplier=0xFF (-1) -> product=0x0001; mcand=0x80 (-128), mplier=0x7F (127) -> product=0xC080; mcand=0x80, mplier=0x80 -> product=0x4000.
- Issue a second start_pulse at SHIFT cycle 5 with different switches -> ignored; spm_x unchanged; done still at cycle 18; product reflects the first operands.
- clear_pulse at SHIFT cycle 7 -> next cycle state IDLE, busy=0, done=0, product=0x0000; a following start gives the correct result.
- start_pulse and clear_pulse in the same cycle from DONE -> clear wins: IDLE, product=0, no spm_clr pulse.
- Reset asserted at SHIFT cycle 10 -> all outputs 0 next cycle; a start_pulse while reset is low is ignored.
